// File: rtl/sevensegment_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: the active-high hex
// glyph table and the scan state encoding.
package sevensegment_scan_pkg;

  // Scan states: GAP is the anti-ghosting dead time, DRIVE lights one digit.
  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; entry n is the glyph for hex n.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return GLYPHS[nib];
  endfunction

endpackage

// File: rtl/sevensegment_scan_sevensegment.sv
// Combinational hex-to-seven-segment decoder, active-high segments {g,f,e,d,c,b,a}.
module sevensegment
  import sevensegment_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = glyph(hex);

endmodule

// File: rtl/sevensegment_scan.sv
// Time-multiplexed seven-segment driver: shadows a packed hex value, then scans
// the digits one at a time with a dead-time gap between digits, per-digit
// decimal point and blanking, and optional leading-zero suppression.
module sevensegment_scan
  import sevensegment_scan_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  lz_suppress,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CMAX = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     DRIVE_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     GAP_LAST   = (GUARD > 0) ? CW'(GUARD - 1) : '0;
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;

  logic [4*DIGITS-1:0] value_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;

  scan_state_t         state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;

  logic [IW-1:0]       nxt_idx;
  logic [IW-1:0]       sel_idx;
  logic [3:0]          sel_nib;
  logic                sel_blank;
  logic                sel_dp;
  logic                sel_zero_above;
  logic                zero_run;
  logic                dark;
  logic [DIGITS-1:0]   an_onehot;
  logic [6:0]          glyph_lit;
  logic [6:0]          slot_seg;
  logic                slot_dp;
  logic [DIGITS-1:0]   slot_an;
  logic                gap_done;
  logic                drive_done;

  // Shadow registers capture the host value whenever load is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_sh <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
    end else if (load) begin
      value_sh <= value;
      dp_sh    <= dp;
      blank_sh <= blank;
    end
  end

  assign nxt_idx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign gap_done   = (GUARD == 0) || (cnt == GAP_LAST);
  assign drive_done = (cnt == DRIVE_LAST);

  // The digit about to be driven: the current one when leaving GAP, the next
  // one when a zero-length gap chains DRIVE straight into DRIVE.
  assign sel_idx = (state == DRIVE) ? nxt_idx : idx;

  // Select the upcoming digit's nibble, flags and leading-zero status.
  always_comb begin
    sel_nib        = '0;
    sel_blank      = 1'b0;
    sel_dp         = 1'b0;
    sel_zero_above = 1'b0;
    zero_run       = 1'b1;
    an_onehot      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (value_sh[4*k +: 4] == 4'h0);
      an_onehot[k] = (IW'(k) == sel_idx);
      if (IW'(k) == sel_idx) begin
        sel_nib        = value_sh[4*k +: 4];
        sel_blank      = blank_sh[k];
        sel_dp         = dp_sh[k];
        sel_zero_above = zero_run;
      end
    end
  end

  sevensegment u_decode (
    .hex  (sel_nib),
    .segs (glyph_lit)
  );

  // Dark digits keep their slot timing but light nothing; digit 0 is never
  // zero-suppressed so an all-zero value still shows a single 0.
  assign dark     = sel_blank | (lz_suppress & (sel_idx != '0) & sel_zero_above);
  assign slot_seg = dark ? SEG_OFF : (SEG_ACTIVE_LOW ? ~glyph_lit : glyph_lit);
  assign slot_dp  = dark ? DP_OFF  : (SEG_ACTIVE_LOW ? ~sel_dp    : sel_dp);
  assign slot_an  = dark ? AN_OFF  : (AN_ACTIVE_LOW  ? ~an_onehot : an_onehot);

  // Scan FSM with registered pin outputs; digit data is sampled only on entry to DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GAP;
      cnt    <= '0;
      idx    <= '0;
      seg    <= SEG_OFF;
      seg_dp <= DP_OFF;
      an     <= AN_OFF;
    end else if (!enable) begin
      state  <= GAP;
      cnt    <= '0;
      seg    <= SEG_OFF;
      seg_dp <= DP_OFF;
      an     <= AN_OFF;
    end else begin
      case (state)
        GAP: begin
          if (gap_done) begin
            state  <= DRIVE;
            cnt    <= '0;
            seg    <= slot_seg;
            seg_dp <= slot_dp;
            an     <= slot_an;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (drive_done) begin
            idx <= nxt_idx;
            cnt <= '0;
            if (GUARD == 0) begin
              seg    <= slot_seg;
              seg_dp <= slot_dp;
              an     <= slot_an;
            end else begin
              state  <= GAP;
              seg    <= SEG_OFF;
              seg_dp <= DP_OFF;
              an     <= AN_OFF;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= GAP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevensegment_scan.sv
// Directed bench for sevensegment_scan: a 4-digit active-low instance with a
// 1-cycle gap, plus a zero-gap active-high-segment instance.
module tb_sevensegment_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        lz_suppress = 1'b0;

  logic [6:0]  seg1, seg2;
  logic        dp1, dp2;
  logic [3:0]  an1, an2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sevensegment_scan #(
    .DIGITS(4), .CLK_DIV(3), .GUARD(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .enable(enable), .lz_suppress(lz_suppress), .seg(seg1), .seg_dp(dp1), .an(an1)
  );

  sevensegment_scan #(
    .DIGITS(4), .CLK_DIV(3), .GUARD(0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .enable(enable), .lz_suppress(lz_suppress), .seg(seg2), .seg_dp(dp2), .an(an2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                        input logic edp);
    chk({tag, " an"}, {12'h0, an1}, {12'h0, ean});
    chk({tag, " seg"}, {9'h0, seg1}, {9'h0, eseg});
    chk({tag, " dp"}, {15'h0, dp1}, {15'h0, edp});
  endtask

  // One digit slot of dut1: three DRIVE samples, then the one-cycle gap.
  task automatic slot(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                      input logic edp);
    repeat (3) begin
      @(negedge clk);
      load = 1'b0;
      check1(tag, ean, eseg, edp);
    end
    @(negedge clk);
    load = 1'b0;
    check1({tag, " gap"}, 4'hF, 7'h7F, 1'b1);
  endtask

  // Realign the scan to digit 0 with new shadow contents (called with idx = 0).
  task automatic reload(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                        input logic lz);
    enable = 1'b0;
    load = 1'b1;
    value = v;
    dp = d;
    blank = b;
    lz_suppress = lz;
    @(negedge clk);
    load = 1'b0;
    enable = 1'b1;
    check1("reload dark", 4'hF, 7'h7F, 1'b1);
  endtask

  logic [3:0] an_tab [4];
  logic [6:0] seg_tab[4];
  logic       dp_tab [4];

  initial begin
    // Reset state of both instances
    @(negedge clk);
    check1("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset dut2 an", {12'h0, an2}, 16'h000F);
    chk("reset dut2 seg", {9'h0, seg2}, 16'h0000);
    chk("reset dut2 dp", {15'h0, dp2}, 16'h0000);
    rst = 1'b0;

    // Test 1: plain scan of 1234
    reload(16'h1234, 4'b0000, 4'b0000, 1'b0);
    slot("t1 d0", 4'b1110, ~7'h66, 1'b1);
    slot("t1 d1", 4'b1101, ~7'h4F, 1'b1);
    slot("t1 d2", 4'b1011, ~7'h5B, 1'b1);
    slot("t1 d3", 4'b0111, ~7'h06, 1'b1);
    slot("t1 d0 again", 4'b1110, ~7'h66, 1'b1);
    slot("t1 d1 again", 4'b1101, ~7'h4F, 1'b1);
    slot("t1 d2 again", 4'b1011, ~7'h5B, 1'b1);
    slot("t1 d3 again", 4'b0111, ~7'h06, 1'b1);

    // Test 2: leading-zero suppression
    reload(16'h00A0, 4'b0000, 4'b0000, 1'b1);
    slot("t2 d0", 4'b1110, ~7'h3F, 1'b1);
    slot("t2 d1", 4'b1101, ~7'h77, 1'b1);
    slot("t2 d2 dark", 4'b1111, 7'h7F, 1'b1);
    slot("t2 d3 dark", 4'b1111, 7'h7F, 1'b1);
    reload(16'h0000, 4'b0000, 4'b0000, 1'b1);
    slot("t2z d0", 4'b1110, ~7'h3F, 1'b1);
    slot("t2z d1 dark", 4'b1111, 7'h7F, 1'b1);
    slot("t2z d2 dark", 4'b1111, 7'h7F, 1'b1);
    slot("t2z d3 dark", 4'b1111, 7'h7F, 1'b1);

    // Test 3: decimal points and blanking (dp[1] set on a blanked digit)
    reload(16'h1234, 4'b0110, 4'b0010, 1'b0);
    slot("t3 d0", 4'b1110, ~7'h66, 1'b1);
    slot("t3 d1 blank", 4'b1111, 7'h7F, 1'b1);
    slot("t3 d2 dp", 4'b1011, ~7'h5B, 1'b0);
    slot("t3 d3", 4'b0111, ~7'h06, 1'b1);

    // Test 4: load coinciding with GAP->DRIVE of digit 2
    reload(16'h1234, 4'b0000, 4'b0000, 1'b0);
    slot("t4 d0", 4'b1110, ~7'h66, 1'b1);
    slot("t4 d1", 4'b1101, ~7'h4F, 1'b1);
    value = 16'hFFFF;
    load = 1'b1;
    slot("t4 d2 old", 4'b1011, ~7'h5B, 1'b1);
    slot("t4 d3 new", 4'b0111, ~7'h71, 1'b1);
    slot("t4 d0 new", 4'b1110, ~7'h71, 1'b1);
    slot("t4 d1 new", 4'b1101, ~7'h71, 1'b1);
    slot("t4 d2 new", 4'b1011, ~7'h71, 1'b1);
    slot("t4 d3 new2", 4'b0111, ~7'h71, 1'b1);

    // Test 5: enable dropped mid-DRIVE of digit 1
    reload(16'h1234, 4'b0000, 4'b0000, 1'b0);
    slot("t5 d0", 4'b1110, ~7'h66, 1'b1);
    @(negedge clk);
    check1("t5 d1 first", 4'b1101, ~7'h4F, 1'b1);
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check1("t5 disabled", 4'hF, 7'h7F, 1'b1);
    end
    enable = 1'b1;
    slot("t5 d1 resumed", 4'b1101, ~7'h4F, 1'b1);
    slot("t5 d2", 4'b1011, ~7'h5B, 1'b1);
    slot("t5 d3", 4'b0111, ~7'h06, 1'b1);

    // Test 6: asynchronous reset mid-DRIVE
    @(negedge clk);
    check1("t6 pre-rst d0", 4'b1110, ~7'h66, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("t6 async rst", 4'hF, 7'h7F, 1'b1);
    chk("t6 async rst dut2 an", {12'h0, an2}, 16'h000F);
    chk("t6 async rst dut2 seg", {9'h0, seg2}, 16'h0000);
    @(negedge clk);
    check1("t6 in rst", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    slot("t6 post-rst d0", 4'b1110, ~7'h3F, 1'b1);
    slot("t6 post-rst d1", 4'b1101, ~7'h3F, 1'b1);

    // Test 6b: zero-gap instance with active-high segments
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6b rst dut2 an", {12'h0, an2}, 16'h000F);
    chk("t6b rst dut2 seg", {9'h0, seg2}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    load = 1'b1;
    value = 16'h8421;
    dp = 4'b0001;
    blank = 4'b0000;
    lz_suppress = 1'b0;
    @(negedge clk);
    load = 1'b0;
    enable = 1'b1;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'h06, 7'h5B, 7'h66, 7'h7F};
    dp_tab  = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("t6b an s%0d", i), {12'h0, an2}, {12'h0, an_tab[(i / 3) % 4]});
      chk($sformatf("t6b seg s%0d", i), {9'h0, seg2}, {9'h0, seg_tab[(i / 3) % 4]});
      chk($sformatf("t6b dp s%0d", i), {15'h0, dp2}, {15'h0, dp_tab[(i / 3) % 4]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
